// File: rtl/acond_pkg.sv
// Shared constants for the sensor conditioning block.
// Holds the datapath widths, the default thresholds and the debounce
// counter width helper used by the top and the debouncer.
package acond_pkg;

  localparam int ANCHO_TEMP     = 8;   // temperature sample width
  localparam int ANCHO_SUMA     = 10;  // 4 x 8-bit running sum
  localparam int UMBRAL_28_DEF  = 28;
  localparam int UMBRAL_30_DEF  = 30;
  localparam int HIST_DEF       = 2;
  localparam int TEMP_MAX_DEF   = 99;
  localparam int DEB_CICLOS_DEF = 16;

  // Counter width able to hold DEB_CICLOS-1.
  function automatic int ancho_deb(input int ciclos);
    return (ciclos > 1) ? $clog2(ciclos) : 1;
  endfunction

endpackage

// File: rtl/acond_sensores_antirrebote.sv
// Debouncer: 2-flop synchroniser, stability counter and output register.
// Latency: output follows a stable raw change 2+DEB_CICLOS edges later.
// Ports: clk, reset (async active-low), raw (async input), salida (debounced).
module antirrebote
  import acond_pkg::*;
#(
  parameter int DEB_CICLOS = DEB_CICLOS_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic salida
);

  localparam int ANCHO_CNT = ancho_deb(DEB_CICLOS);
  localparam logic [ANCHO_CNT-1:0] CNT_FIN = ANCHO_CNT'(DEB_CICLOS - 1);

  logic                 sinc1_q, sinc1_d;
  logic                 sinc2_q, sinc2_d;
  logic                 sal_q, sal_d;
  logic [ANCHO_CNT-1:0] cnt_q, cnt_d;

  always_comb begin
    sinc1_d = raw;
    sinc2_d = sinc1_q;
    sal_d   = sal_q;
    cnt_d   = '0;
    // Count only while the synchronised input disagrees with the output;
    // any agreement restarts the count, so short glitches never toggle.
    if (sinc2_q != sal_q) begin
      if (cnt_q == CNT_FIN) begin
        sal_d = ~sal_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sinc1_q <= 1'b0;
      sinc2_q <= 1'b0;
      sal_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sinc1_q <= sinc1_d;
      sinc2_q <= sinc2_d;
      sal_q   <= sal_d;
      cnt_q   <= cnt_d;
    end
  end

  assign salida = sal_q;

endmodule

// File: rtl/acond_sensores.sv
// Input conditioning ahead of the climate/alarm FSM: 4-sample moving average
// with hysteresis thresholds on temperature, debounce on presence/ignition.
// Ports: clk, reset (async active-low), dato_temp/dato_valido in; Temp_28,
// Temp_30, Presencia, Ignicion, promedio, promedio_valido, error_sensor out.
module acond_sensores
  import acond_pkg::*;
#(
  parameter int UMBRAL_28  = UMBRAL_28_DEF,
  parameter int UMBRAL_30  = UMBRAL_30_DEF,
  parameter int HIST       = HIST_DEF,
  parameter int TEMP_MAX   = TEMP_MAX_DEF,
  parameter int DEB_CICLOS = DEB_CICLOS_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ANCHO_TEMP-1:0] dato_temp,
  input  logic                  dato_valido,
  input  logic                  presencia_raw,
  input  logic                  ignicion_raw,
  output logic                  Temp_28,
  output logic                  Temp_30,
  output logic                  Presencia,
  output logic                  Ignicion,
  output logic [ANCHO_TEMP-1:0] promedio,
  output logic                  promedio_valido,
  output logic                  error_sensor
);

  localparam logic [ANCHO_TEMP-1:0] T_MAX   = ANCHO_TEMP'(TEMP_MAX);
  localparam logic [ANCHO_TEMP-1:0] U28     = ANCHO_TEMP'(UMBRAL_28);
  localparam logic [ANCHO_TEMP-1:0] U28_BAJ = ANCHO_TEMP'(UMBRAL_28 - HIST);
  localparam logic [ANCHO_TEMP-1:0] U30     = ANCHO_TEMP'(UMBRAL_30);
  localparam logic [ANCHO_TEMP-1:0] U30_BAJ = ANCHO_TEMP'(UMBRAL_30 - HIST);
  localparam logic [2:0]            LLENO   = 3'd4;

  // win_q[0] is the newest sample, win_q[3] the oldest.
  logic [3:0][ANCHO_TEMP-1:0] win_q, win_d;
  logic [ANCHO_SUMA-1:0]      suma_q, suma_d;
  logic [2:0]                 cnt_q, cnt_d;
  logic                       acept_q, acept_d;
  logic                       rech_q, rech_d;
  logic                       err_q, err_d;
  logic [ANCHO_TEMP-1:0]      prom_q, prom_d;
  logic                       pv_q, pv_d;
  logic                       t28_q, t28_d;
  logic                       t30_q, t30_d;
  logic [ANCHO_TEMP-1:0]      prom_nuevo;
  logic                       aceptar;

  assign aceptar = dato_valido && (dato_temp <= T_MAX);

  always_comb begin
    win_d      = win_q;
    suma_d     = suma_q;
    cnt_d      = cnt_q;
    acept_d    = aceptar;
    rech_d     = dato_valido && !aceptar;
    err_d      = err_q | rech_q;
    prom_d     = prom_q;
    pv_d       = 1'b0;
    t28_d      = t28_q;
    t30_d      = t30_q;
    prom_nuevo = suma_q[ANCHO_SUMA-1:2];

    if (aceptar) begin
      win_d  = {win_q[2:0], dato_temp};
      // The sum always contains the oldest sample, so this never underflows.
      suma_d = suma_q + {2'b00, dato_temp} - {2'b00, win_q[3]};
      cnt_d  = (cnt_q == LLENO) ? LLENO : cnt_q + 3'd1;
    end

    // Publish the average one edge after the sample that completed it.
    if (acept_q && (cnt_q == LLENO)) begin
      prom_d = prom_nuevo;
      pv_d   = 1'b1;
      // Hysteresis: set at/above U, clear below U-HIST, hold in between.
      // With U28 < U30 and equal HIST, Temp_30 can never be 1 while Temp_28 is 0.
      if (prom_nuevo >= U28)          t28_d = 1'b1;
      else if (prom_nuevo < U28_BAJ)  t28_d = 1'b0;
      if (prom_nuevo >= U30)          t30_d = 1'b1;
      else if (prom_nuevo < U30_BAJ)  t30_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_q   <= '0;
      suma_q  <= '0;
      cnt_q   <= '0;
      acept_q <= 1'b0;
      rech_q  <= 1'b0;
      err_q   <= 1'b0;
      prom_q  <= '0;
      pv_q    <= 1'b0;
      t28_q   <= 1'b0;
      t30_q   <= 1'b0;
    end else begin
      win_q   <= win_d;
      suma_q  <= suma_d;
      cnt_q   <= cnt_d;
      acept_q <= acept_d;
      rech_q  <= rech_d;
      err_q   <= err_d;
      prom_q  <= prom_d;
      pv_q    <= pv_d;
      t28_q   <= t28_d;
      t30_q   <= t30_d;
    end
  end

  assign Temp_28         = t28_q;
  assign Temp_30         = t30_q;
  assign promedio        = prom_q;
  assign promedio_valido = pv_q;
  assign error_sensor    = err_q;

  antirrebote #(.DEB_CICLOS(DEB_CICLOS)) u_deb_presencia (
    .clk    (clk),
    .reset  (reset),
    .raw    (presencia_raw),
    .salida (Presencia)
  );

  antirrebote #(.DEB_CICLOS(DEB_CICLOS)) u_deb_ignicion (
    .clk    (clk),
    .reset  (reset),
    .raw    (ignicion_raw),
    .salida (Ignicion)
  );

endmodule

// File: tb/tb_acond_sensores.sv
// Testbench for acond_sensores: scoreboard of expected averages/flags plus
// scenario tasks for reset, warm-up, hysteresis, truncation, debounce,
// back-to-back samples, rejection and mid-stream reset.
module tb_acond_sensores;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] dato_temp = 8'd0;
  logic       dato_valido = 1'b0;
  logic       presencia_raw = 1'b0;
  logic       ignicion_raw = 1'b0;
  logic       Temp_28, Temp_30, Presencia, Ignicion;
  logic [7:0] promedio;
  logic       promedio_valido, error_sensor;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pulsos = 0;

  typedef struct {
    int prom;
    bit t28;
    bit t30;
  } exp_t;

  exp_t sb[$];
  int   m_win[4];
  int   m_cnt;
  bit   m_t28, m_t30;

  acond_sensores dut (
    .clk             (clk),
    .reset           (reset),
    .dato_temp       (dato_temp),
    .dato_valido     (dato_valido),
    .presencia_raw   (presencia_raw),
    .ignicion_raw    (ignicion_raw),
    .Temp_28         (Temp_28),
    .Temp_30         (Temp_30),
    .Presencia       (Presencia),
    .Ignicion        (Ignicion),
    .promedio        (promedio),
    .promedio_valido (promedio_valido),
    .error_sensor    (error_sensor)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_win[i] = 0;
    m_cnt = 0;
    m_t28 = 1'b0;
    m_t30 = 1'b0;
    sb.delete();
  endfunction

  function automatic void model_sample(input int v);
    exp_t e;
    int   p;
    if (v > 99) return;
    m_win[3] = m_win[2];
    m_win[2] = m_win[1];
    m_win[1] = m_win[0];
    m_win[0] = v;
    if (m_cnt < 4) m_cnt++;
    if (m_cnt == 4) begin
      p = (m_win[0] + m_win[1] + m_win[2] + m_win[3]) / 4;
      if (p >= 28) m_t28 = 1'b1; else if (p < 26) m_t28 = 1'b0;
      if (p >= 30) m_t30 = 1'b1; else if (p < 28) m_t30 = 1'b0;
      e.prom = p;
      e.t28  = m_t28;
      e.t30  = m_t30;
      sb.push_back(e);
    end
  endfunction

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (reset) begin
      n_tests++;
      if (Temp_30 && !Temp_28) begin
        n_fail++;
        $display("FAIL invariant: Temp_30=%0b Temp_28=%0b", Temp_30, Temp_28);
      end
      if (promedio_valido) begin
        exp_t e;
        n_pulsos++;
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_valid: promedio=%0d with nothing expected", promedio);
        end else begin
          e = sb.pop_front();
          if (promedio !== 8'(e.prom) || Temp_28 !== e.t28 || Temp_30 !== e.t30) begin
            n_fail++;
            $display("FAIL scoreboard: got prom=%0d t28=%0b t30=%0b, want prom=%0d t28=%0b t30=%0b",
                     promedio, Temp_28, Temp_30, e.prom, e.t28, e.t30);
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int v);
    @(posedge clk);
    #1;
    dato_temp   = 8'(v);
    dato_valido = 1'b1;
    model_sample(v);
    @(posedge clk);
    #1;
    dato_valido = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 20) begin
      @(posedge clk);
      t++;
    end
    @(negedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d expected updates never arrived, want 0", sb.size());
      sb.delete();
    end
  endtask

  // Called right after send() returns: checks the update at edge k+1.
  task automatic check_update(input string nm, input int p, input bit t28, input bit t30);
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (promedio_valido !== 1'b1 || promedio !== 8'(p) || Temp_28 !== t28 || Temp_30 !== t30) begin
      n_fail++;
      $display("FAIL %s: got v=%0b prom=%0d t28=%0b t30=%0b, want v=1 prom=%0d t28=%0b t30=%0b",
               nm, promedio_valido, promedio, Temp_28, Temp_30, p, t28, t30);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [13:0] outs;
    model_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    outs = {Temp_28, Temp_30, Presencia, Ignicion, promedio, promedio_valido, error_sensor};
    n_tests++;
    if (outs !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, want 0", outs);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    outs = {Temp_28, Temp_30, Presencia, Ignicion, promedio, promedio_valido, error_sensor};
    n_tests++;
    if (outs !== 14'd0) begin
      n_fail++;
      $display("FAIL release_idle: got %h, want 0", outs);
    end
  endtask

  task automatic test_warmup();
    int pulsos0 = n_pulsos;
    for (int i = 0; i < 3; i++) send(35);
    repeat (3) @(negedge clk);
    n_tests++;
    if (Temp_28 !== 1'b0 || Temp_30 !== 1'b0 || n_pulsos != pulsos0) begin
      n_fail++;
      $display("FAIL warmup: got t28=%0b t30=%0b pulses=%0d, want 0 0 0",
               Temp_28, Temp_30, n_pulsos - pulsos0);
    end
    send(35);
    check_update("warmup_fourth", 35, 1'b1, 1'b1);
    @(negedge clk);
    n_tests++;
    if (promedio_valido !== 1'b0) begin
      n_fail++;
      $display("FAIL pulse_width: promedio_valido=%0b one cycle later, want 0", promedio_valido);
    end
    drain();
  endtask

  task automatic test_hysteresis();
    int p27[4] = '{33, 31, 29, 27};
    bit f30[4] = '{1, 1, 1, 0};
    int p25[4] = '{26, 26, 25, 25};
    bit f28[4] = '{1, 1, 0, 0};
    for (int i = 0; i < 4; i++) begin
      send(27);
      check_update($sformatf("hyst27_%0d", i), p27[i], 1'b1, f30[i]);
    end
    for (int i = 0; i < 4; i++) begin
      send(25);
      check_update($sformatf("hyst25_%0d", i), p25[i], f28[i], 1'b0);
    end
    drain();
  endtask

  task automatic test_truncation();
    do_reset();
    send(28); send(28); send(28); send(29);
    check_update("trunc_113", 28, 1'b1, 1'b0);
    drain();
    do_reset();
    send(27); send(28); send(28); send(28);
    check_update("trunc_111", 27, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_back_to_back();
    int vals[4] = '{40, 50, 60, 70};
    int pulsos0 = n_pulsos;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      #1;
      dato_temp   = 8'(vals[i]);
      dato_valido = 1'b1;
      model_sample(vals[i]);
      @(posedge clk);
    end
    #1;
    dato_valido = 1'b0;
    drain();
    n_tests++;
    if (n_pulsos - pulsos0 != 4) begin
      n_fail++;
      $display("FAIL back_to_back_pulses: got %0d, want 4", n_pulsos - pulsos0);
    end
  endtask

  task automatic test_debounce();
    bit visto;
    // short glitch
    @(posedge clk);
    #1 presencia_raw = 1'b1;
    repeat (10) @(posedge clk);
    #1 presencia_raw = 1'b0;
    visto = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (Presencia !== 1'b0) visto = 1'b1;
    end
    n_tests++;
    if (visto) begin
      n_fail++;
      $display("FAIL glitch_10: Presencia went to 1, want 0");
    end
    // exact latency
    @(posedge clk);
    #1 presencia_raw = 1'b1;
    for (int e = 1; e <= 18; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 17 || e == 18) begin
        n_tests++;
        if (Presencia !== (e == 18)) begin
          n_fail++;
          $display("FAIL deb_latency_edge%0d: Presencia=%0b, want %0b", e, Presencia, e == 18);
        end
      end
    end
    repeat (12) @(posedge clk);
    #1 presencia_raw = 1'b0;
    repeat (25) @(negedge clk);
    n_tests++;
    if (Presencia !== 1'b0) begin
      n_fail++;
      $display("FAIL deb_fall: Presencia=%0b, want 0", Presencia);
    end
    // ignition chatter
    visto = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 ignicion_raw = ~ignicion_raw;
      repeat (2) @(posedge clk);
      if (Ignicion !== 1'b0) visto = 1'b1;
    end
    #1 ignicion_raw = 1'b0;
    n_tests++;
    if (visto) begin
      n_fail++;
      $display("FAIL ign_chatter: Ignicion changed, want constant 0");
    end
  endtask

  task automatic test_rejection();
    logic [13:0] outs;
    int pulsos0 = n_pulsos;
    send(120);
    @(negedge clk);
    n_tests++;
    if (error_sensor !== 1'b0) begin
      n_fail++;
      $display("FAIL err_timing_k: error_sensor=%0b at edge k, want 0", error_sensor);
    end
    @(negedge clk);
    n_tests++;
    if (error_sensor !== 1'b1 || n_pulsos != pulsos0) begin
      n_fail++;
      $display("FAIL reject: error=%0b pulses=%0d, want 1 0", error_sensor, n_pulsos - pulsos0);
    end
    // window must be unchanged: the scoreboard checks the next average
    send(50);
    drain();
    repeat (10) @(negedge clk);
    n_tests++;
    if (error_sensor !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: error_sensor=%0b, want 1", error_sensor);
    end
    // mid-stream reset
    send(60);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    #3;
    outs = {Temp_28, Temp_30, Presencia, Ignicion, promedio, promedio_valido, error_sensor};
    n_tests++;
    if (outs !== 14'd0) begin
      n_fail++;
      $display("FAIL midreset_async: got %h, want 0", outs);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    pulsos0 = n_pulsos;
    for (int i = 0; i < 3; i++) send(40);
    repeat (3) @(negedge clk);
    n_tests++;
    if (n_pulsos != pulsos0 || Temp_28 !== 1'b0) begin
      n_fail++;
      $display("FAIL rewarmup: pulses=%0d t28=%0b, want 0 0", n_pulsos - pulsos0, Temp_28);
    end
    send(40);
    check_update("rewarmup_fourth", 40, 1'b1, 1'b1);
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_warmup();
    test_hysteresis();
    test_truncation();
    test_back_to_back();
    test_debounce();
    test_rejection();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
